// File: rtl/dr_sync_sink_pkg.sv
// Shared definitions for the dual-rail synchronizing sink: handshake states
// and the rail index of each logic value within a dual-rail bit.
package dr_sync_sink_pkg;

  typedef enum logic {
    WAIT_DATA = 1'b0,
    WAIT_NULL = 1'b1
  } state_t;

  localparam int RAIL_ZERO = 0;
  localparam int RAIL_ONE  = 1;

endpackage

// File: rtl/dr_sync_sink_sync_fifo.sv
// Single-clock FIFO holding decoded tokens; a push into a full FIFO is
// accepted when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_level
);

  localparam int LW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [LW-1:0]    r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full   = (r_count == FULL_LEVEL);
  assign o_empty  = (r_count == '0);
  assign o_level  = r_count;
  assign o_data   = r_mem[r_rdPtr];
  assign w_doPop  = i_pop & ~o_empty;
  assign w_doPush = i_push & (~o_full | w_doPop);

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= i_data;
        r_wrPtr        <= r_wrPtr + 1'b1;
      end
      if (w_doPop) r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dr_sync_sink.sv
// Receives four-phase return-to-zero dual-rail tokens from an asynchronous
// domain, synchronizes every rail, and queues decoded words in a FIFO.
module dr_sync_sink
  import dr_sync_sink_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0][1:0]      in,
  output logic                       ack_o,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       err
);

  logic [WIDTH-1:0][1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0][1:0] w_rails;
  logic [WIDTH-1:0]      w_word;
  logic                  w_allValid;
  logic                  w_allNull;
  logic                  w_illegal;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  state_t                r_state;
  state_t                w_nextState;
  logic                  r_err;

  // Raw rails go straight into the first flop of each synchronizer chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= in;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_rails = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_allValid = 1'b1;
    w_allNull  = 1'b1;
    w_illegal  = 1'b0;
    w_word     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_word[i] = w_rails[i][RAIL_ONE];
      if (w_rails[i][RAIL_ZERO] == w_rails[i][RAIL_ONE]) w_allValid = 1'b0;
      if (|w_rails[i]) w_allNull = 1'b0;
      if (&w_rails[i]) w_illegal = 1'b1;
    end
  end

  assign w_pop     = out_valid & out_ready;
  assign out_valid = ~w_empty;

  // A full FIFO only accepts the token when a pop frees a slot on the same edge.
  always_comb begin
    w_nextState = r_state;
    w_push      = 1'b0;
    case (r_state)
      WAIT_DATA: begin
        if (w_allValid && (!w_full || w_pop)) begin
          w_push      = 1'b1;
          w_nextState = WAIT_NULL;
        end
      end
      WAIT_NULL: begin
        if (w_allNull) w_nextState = WAIT_DATA;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= WAIT_DATA;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_err   <= r_err | w_illegal;
    end
  end

  assign ack_o = (r_state == WAIT_NULL);
  assign err   = r_err;

  sync_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_data (w_word),
    .o_data (out_data),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_level(level)
  );

endmodule

// File: tb/tb_dr_sync_sink.sv
// Directed self-checking bench for dr_sync_sink with default parameters
// (WIDTH=32, DEPTH=4, SYNC_STAGES=2).
module tb_dr_sync_sink;

  localparam int W = 32;
  typedef logic [W-1:0][1:0] dr_t;

  typedef struct {
    logic [31:0] value;
    logic [31:0] expData;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  dr_t             in;
  logic            ack_o;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [2:0]      level;
  logic            err;

  int vectors     = 0;
  int miscompares = 0;

  dr_sync_sink dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .ack_o    (ack_o),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level    (level),
    .err      (err)
  );

  always #5 clk = ~clk;

  function automatic dr_t encode(input logic [31:0] v);
    dr_t t;
    for (int i = 0; i < W; i++) t[i] = {v[i], ~v[i]};
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input dr_t value);
    in = value;
  endtask

  task automatic waitAck(input logic target, input int bound, output int cycles);
    cycles = -1;
    for (int n = 1; n <= bound; n++) begin
      tick();
      if (ack_o === target) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic sendToken(input logic [31:0] v, input string tag);
    int c;
    applyStimulus(encode(v));
    waitAck(1'b1, 12, c);
    checkOutput({tag, " ack rise latency"}, 32'(c), 32'd3);
  endtask

  task automatic releaseToken(input string tag);
    int c;
    applyStimulus('0);
    waitAck(1'b0, 12, c);
    checkOutput({tag, " ack fall latency"}, 32'(c), 32'd3);
  endtask

  task automatic popOne();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs [5];
    logic [31:0] fib  [5];
    logic [31:0] dv;
    dr_t         tok;
    logic        earlyAck;
    int          c;

    vecs[0] = '{32'h0000_0005, 32'h0000_0005};
    vecs[1] = '{32'h0000_0000, 32'h0000_0000};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[3] = '{32'hA5A5_5A5A, 32'hA5A5_5A5A};
    vecs[4] = '{32'h1234_5678, 32'h1234_5678};
    fib[0] = 32'd1; fib[1] = 32'd1; fib[2] = 32'd2; fib[3] = 32'd3; fib[4] = 32'd5;

    rst       = 1'b1;
    in        = '0;
    out_ready = 1'b0;
    tick();
    tick();
    checkOutput("reset ack_o", 32'(ack_o), 32'd0);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset level", 32'(level), 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);
    checkOutput("reset out_data", out_data, 32'd0);
    rst = 1'b0;
    tick();

    // Table of complete single-token handshakes
    for (int k = 0; k < 5; k++) begin
      sendToken(vecs[k].value, $sformatf("vec%0d", k));
      checkOutput($sformatf("vec%0d out_data", k), out_data, vecs[k].expData);
      checkOutput($sformatf("vec%0d out_valid", k), 32'(out_valid), 32'd1);
      checkOutput($sformatf("vec%0d level", k), 32'(level), 32'd1);
      releaseToken($sformatf("vec%0d", k));
      popOne();
      checkOutput($sformatf("vec%0d drained", k), 32'(out_valid), 32'd0);
    end

    // Skewed arrival, one bit per cycle
    dv       = 32'hDEAD_BEEF;
    tok      = '0;
    earlyAck = 1'b0;
    for (int i = 0; i < 31; i++) begin
      tok[i] = {dv[i], ~dv[i]};
      applyStimulus(tok);
      tick();
      if (ack_o !== 1'b0 || level !== 3'd0) earlyAck = 1'b1;
    end
    checkOutput("skew no early push", 32'(earlyAck), 32'd0);
    tok[31] = {dv[31], ~dv[31]};
    applyStimulus(tok);
    waitAck(1'b1, 12, c);
    checkOutput("skew ack rise latency", 32'(c), 32'd3);
    checkOutput("skew out_data", out_data, 32'hDEAD_BEEF);
    checkOutput("skew level", 32'(level), 32'd1);
    releaseToken("skew");
    popOne();
    checkOutput("skew drained level", 32'(level), 32'd0);

    // Backpressure with Fibonacci words
    for (int k = 0; k < 4; k++) begin
      sendToken(fib[k], $sformatf("fib%0d", k));
      releaseToken($sformatf("fib%0d", k));
    end
    checkOutput("bp level full", 32'(level), 32'd4);
    applyStimulus(encode(fib[4]));
    repeat (8) tick();
    checkOutput("bp fifth held ack", 32'(ack_o), 32'd0);
    checkOutput("bp fifth held level", 32'(level), 32'd4);
    checkOutput("bp drain word0", out_data, fib[0]);
    popOne();
    checkOutput("bp ack after pop", 32'(ack_o), 32'd1);
    checkOutput("bp level after pop", 32'(level), 32'd4);
    releaseToken("bp fifth");
    for (int k = 1; k < 5; k++) begin
      checkOutput($sformatf("bp drain word%0d", k), out_data, fib[k]);
      popOne();
    end
    checkOutput("bp drained level", 32'(level), 32'd0);

    // Full FIFO, token completes on the same cycle as a pop
    for (int k = 0; k < 4; k++) begin
      sendToken(32'h10 + 32'(k), $sformatf("fp%0d", k));
      releaseToken($sformatf("fp%0d", k));
    end
    applyStimulus(encode(32'h14));
    tick();
    tick();
    checkOutput("fp not yet acked", 32'(ack_o), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("fp ack same-cycle pop", 32'(ack_o), 32'd1);
    checkOutput("fp level unchanged", 32'(level), 32'd4);
    releaseToken("fp fifth");
    for (int k = 1; k < 5; k++) begin
      checkOutput($sformatf("fp drain word%0d", k), out_data, 32'h10 + 32'(k));
      popOne();
    end
    checkOutput("fp drained level", 32'(level), 32'd0);

    // Illegal code on bit 7
    tok    = encode(32'h0);
    tok[7] = 2'b11;
    applyStimulus(tok);
    tick();
    tick();
    checkOutput("illegal err before sync", 32'(err), 32'd0);
    tick();
    checkOutput("illegal err set", 32'(err), 32'd1);
    checkOutput("illegal ack", 32'(ack_o), 32'd0);
    repeat (5) tick();
    checkOutput("illegal no push", 32'(level), 32'd0);
    checkOutput("illegal ack held low", 32'(ack_o), 32'd0);
    applyStimulus('0);
    repeat (5) tick();
    checkOutput("illegal err sticky", 32'(err), 32'd1);

    // Reset in the middle of a handshake
    sendToken(32'h111, "rst tok0");
    releaseToken("rst tok0");
    sendToken(32'h222, "rst tok1");
    checkOutput("rst pre level", 32'(level), 32'd2);
    rst = 1'b1;
    #1;
    checkOutput("rst async ack", 32'(ack_o), 32'd0);
    checkOutput("rst async level", 32'(level), 32'd0);
    checkOutput("rst async err", 32'(err), 32'd0);
    checkOutput("rst async out_valid", 32'(out_valid), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    waitAck(1'b1, 12, c);
    checkOutput("rst recapture latency", 32'(c), 32'd3);
    checkOutput("rst recapture data", out_data, 32'h222);
    repeat (6) tick();
    checkOutput("rst recapture once", 32'(level), 32'd1);
    releaseToken("rst recapture");
    checkOutput("rst level after null", 32'(level), 32'd1);
    popOne();
    checkOutput("rst final level", 32'(level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
